// File: rtl/ram_scrub_arb.sv
// Port-1 controller for a parity-protected dual-port RAM. Arbitrates the port between a host
// requester and a background scrubber that reads every word in turn, samples the RAM parity
// flag and logs errors (first address, saturating count, sticky valid, interrupt).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   host_req_i/we_i/adr_i/dat_i     host request, held until host_ack_o
//   host_ack_o/dat_o/perr_o         one-cycle completion with read data and parity flag
//   scrub_en_i                      runs the scrub interval counter
//   err_clr_i, irq_en_i             error log clear, interrupt enable
//   ram_adr_o/dat_o/we_o            RAM port-1 command
//   ram_dat_i, ram_perr_i           RAM registered read data, combinational parity flag
//   err_valid_o/adr_o/cnt_o         scrub error log
//   pass_done_o, irq_o              end-of-pass pulse, registered interrupt
module ram_scrub_arb #(
  parameter int unsigned DAT_WIDTH      = 32,
  parameter int unsigned ADR_WIDTH      = 10,
  parameter int unsigned MEM_SIZE       = 1024,
  parameter int unsigned SCRUB_INTERVAL = 256,
  parameter int unsigned MAX_WAIT       = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_req_i,
  input  logic                 host_we_i,
  input  logic [ADR_WIDTH-1:0] host_adr_i,
  input  logic [DAT_WIDTH-1:0] host_dat_i,
  output logic                 host_ack_o,
  output logic [DAT_WIDTH-1:0] host_dat_o,
  output logic                 host_perr_o,
  input  logic                 scrub_en_i,
  input  logic                 err_clr_i,
  input  logic                 irq_en_i,
  output logic [ADR_WIDTH-1:0] ram_adr_o,
  output logic [DAT_WIDTH-1:0] ram_dat_o,
  output logic                 ram_we_o,
  input  logic [DAT_WIDTH-1:0] ram_dat_i,
  input  logic                 ram_perr_i,
  output logic                 err_valid_o,
  output logic [ADR_WIDTH-1:0] err_adr_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 pass_done_o,
  output logic                 irq_o
);

  localparam int unsigned IcW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int unsigned WcW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  // The pending flag is raised on the increment that reaches SCRUB_INTERVAL-1, so together
  // with the grant cycle there are SCRUB_INTERVAL idle cycles between scrub reads.
  localparam logic [IcW-1:0]       IcLast  = IcW'((SCRUB_INTERVAL >= 2) ? SCRUB_INTERVAL - 2 : 0);
  localparam logic [WcW-1:0]       WcMax   = WcW'(MAX_WAIT);
  localparam logic [ADR_WIDTH-1:0] PtrLast = ADR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StHAcc, StHRsp, StSAcc, StSRsp} state_e;

  state_e                state_q, state_d;
  logic [ADR_WIDTH-1:0]  adr_q, ptr_q, ptr_d, err_adr_q, err_adr_d;
  logic [DAT_WIDTH-1:0]  wdat_q, hdat_q;
  logic [IcW-1:0]        icnt_q, icnt_d;
  logic [WcW-1:0]        wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  pend_q, pend_d, perr_q, perr_d, we_q, we_d;
  logic                  err_valid_q, err_valid_d, irq_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    icnt_d      = icnt_q;
    wcnt_d      = wcnt_q;
    pend_d      = pend_q;
    perr_d      = perr_q;
    we_d        = we_q;
    err_valid_d = err_valid_q;
    err_adr_d   = err_adr_q;
    err_cnt_d   = err_cnt_q;
    ram_adr_o   = adr_q;   // address and data hold their last driven values
    ram_dat_o   = wdat_q;
    ram_we_o    = 1'b0;
    host_ack_o  = 1'b0;
    host_dat_o  = hdat_q;
    host_perr_o = 1'b0;
    pass_done_o = 1'b0;

    if (scrub_en_i && !pend_q) begin
      if (icnt_q == IcLast) begin
        icnt_d = '0;
        pend_d = 1'b1;
      end else begin
        icnt_d = icnt_q + 1'b1;
      end
    end

    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_cnt_d   = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q && (wcnt_q >= WcMax || !host_req_i)) begin
          state_d = StSAcc;
          wcnt_d  = '0;
        end else if (host_req_i) begin
          state_d = StHAcc;
          if (pend_q && wcnt_q < WcMax) wcnt_d = wcnt_q + 1'b1;
        end
      end
      StHAcc: begin
        ram_adr_o = host_adr_i;
        ram_dat_o = host_dat_i;
        ram_we_o  = host_we_i;
        we_d      = host_we_i;
        perr_d    = ram_perr_i & ~host_we_i;
        state_d   = StHRsp;
      end
      StHRsp: begin
        host_ack_o  = 1'b1;
        host_perr_o = perr_q;
        if (!we_q) host_dat_o = ram_dat_i;
        state_d = StIdle;
      end
      StSAcc: begin
        ram_adr_o = ptr_q;
        perr_d    = ram_perr_i;
        state_d   = StSRsp;
      end
      StSRsp: begin
        pend_d = 1'b0;
        if (perr_q) begin
          // A fresh error in the clear cycle survives the clear.
          err_valid_d = 1'b1;
          if (err_clr_i) begin
            err_cnt_d = CNT_WIDTH'(1);
          end else if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (err_clr_i || !err_valid_q) err_adr_d = ptr_q;
        end
        if (ptr_q == PtrLast) begin
          ptr_d       = '0;
          pass_done_o = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      wdat_q      <= '0;
      hdat_q      <= '0;
      ptr_q       <= '0;
      icnt_q      <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      perr_q      <= 1'b0;
      we_q        <= 1'b0;
      err_valid_q <= 1'b0;
      err_adr_q   <= '0;
      err_cnt_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= ram_adr_o;
      wdat_q      <= ram_dat_o;
      hdat_q      <= host_dat_o;
      ptr_q       <= ptr_d;
      icnt_q      <= icnt_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      perr_q      <= perr_d;
      we_q        <= we_d;
      err_valid_q <= err_valid_d;
      err_adr_q   <= err_adr_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= err_valid_q & irq_en_i;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_adr_o   = err_adr_q;
  assign err_cnt_o   = err_cnt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_ram_scrub_arb.sv
module tb_ram_scrub_arb;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MS = 8;
  localparam int SI = 4;
  localparam int MW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req_i, host_we_i, host_ack_o, host_perr_o;
  logic [AW-1:0] host_adr_i, ram_adr_o, err_adr_o;
  logic [DW-1:0] host_dat_i, host_dat_o, ram_dat_o, ram_dat_i;
  logic          scrub_en_i, err_clr_i, irq_en_i, ram_we_o, ram_perr_i;
  logic          err_valid_o, pass_done_o, irq_o;
  logic [CW-1:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_scrub_arb #(
    .DAT_WIDTH(DW), .ADR_WIDTH(AW), .MEM_SIZE(MS), .SCRUB_INTERVAL(SI), .MAX_WAIT(MW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_adr_i(host_adr_i),
    .host_dat_i(host_dat_i), .host_ack_o(host_ack_o), .host_dat_o(host_dat_o),
    .host_perr_o(host_perr_o), .scrub_en_i(scrub_en_i), .err_clr_i(err_clr_i),
    .irq_en_i(irq_en_i), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_we_o(ram_we_o),
    .ram_dat_i(ram_dat_i), .ram_perr_i(ram_perr_i), .err_valid_o(err_valid_o),
    .err_adr_o(err_adr_o), .err_cnt_o(err_cnt_o), .pass_done_o(pass_done_o), .irq_o(irq_o)
  );

  // RAM port 1: registered read, parity flag combinational on the address.
  logic [DW-1:0] mem [MS];
  logic          bad [MS];
  logic          ram_load;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < MS; i++) mem[i] <= init_word(i);
    end else begin
      ram_dat_i <= mem[ram_adr_o];
      if (ram_we_o) mem[ram_adr_o] <= ram_dat_o;
    end
  end
  assign ram_perr_i = bad[ram_adr_o];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: each granted access is a record with its grant cycle; the access phase is
  // one cycle after grant and the response two cycles after.
  logic [DW-1:0] m_mem [MS];
  int            cyc, op_kind, op_t0, icnt, wcnt, ptr, eadr, ecnt;
  logic [AW-1:0] op_adr, last_adr;
  logic          op_we, op_perr, pend, ev, irq;
  logic [DW-1:0] last_wdat, last_hdat;

  always @(negedge clk) begin : model
    int            ph, necnt, neadr;
    logic          nev, npend, e_we, e_ack, e_perr, e_pd;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wdat, e_hdat;
    if (ram_load) for (int i = 0; i < MS; i++) m_mem[i] = init_word(i);
    if (!rst_n) begin
      cyc = 0; op_kind = 0; op_t0 = 0; icnt = 0; wcnt = 0; ptr = 0; eadr = 0; ecnt = 0;
      pend = 0; ev = 0; irq = 0; op_perr = 0; op_we = 0; op_adr = '0;
      last_adr = '0; last_wdat = '0; last_hdat = '0;
    end else begin
      ph = (op_kind != 0) ? cyc - op_t0 : 0;
      e_adr = last_adr; e_wdat = last_wdat; e_we = 0; e_ack = 0; e_hdat = last_hdat;
      e_perr = 0; e_pd = 0;
      if (op_kind == 1 && ph == 1) begin
        e_adr = host_adr_i; e_wdat = host_dat_i; e_we = host_we_i;
      end else if (op_kind == 1 && ph == 2) begin
        e_ack = 1;
        if (!op_we) begin e_hdat = m_mem[op_adr]; e_perr = op_perr; end
      end else if (op_kind == 2 && ph == 1) begin
        e_adr = AW'(ptr);
      end else if (op_kind == 2 && ph == 2) begin
        e_pd = (ptr == MS - 1);
      end
      chk("ram_adr", ram_adr_o, e_adr);
      chk("ram_dat", ram_dat_o, e_wdat);
      chk("ram_we", ram_we_o, e_we);
      chk("host_ack", host_ack_o, e_ack);
      chk("host_dat", host_dat_o, e_hdat);
      chk("host_perr", host_perr_o, e_perr);
      chk("pass_done", pass_done_o, e_pd);
      chk("err_valid", err_valid_o, ev);
      chk("err_adr", err_adr_o, eadr);
      chk("err_cnt", err_cnt_o, ecnt);
      chk("irq", irq_o, irq);
      // advance to the next cycle
      nev = ev; necnt = ecnt; neadr = eadr; npend = pend;
      if (op_kind == 1 && ph == 1) begin
        op_adr = host_adr_i; op_we = host_we_i;
        op_perr = host_we_i ? 1'b0 : bad[host_adr_i];
        if (host_we_i) m_mem[host_adr_i] = host_dat_i;
      end
      if (op_kind == 2 && ph == 1) op_perr = bad[ptr];
      if (err_clr_i) begin nev = 0; necnt = 0; end
      if (op_kind == 2 && ph == 2) begin
        npend = 0;
        if (op_perr) begin
          necnt = err_clr_i ? 1 : ((ecnt == 255) ? 255 : ecnt + 1);
          if (err_clr_i || !ev) neadr = ptr;
          nev = 1;
        end
        ptr = (ptr == MS - 1) ? 0 : ptr + 1;
      end
      irq = ev & irq_en_i;
      if (scrub_en_i && !pend) begin
        icnt++;
        if (icnt >= SI - 1) begin npend = 1; icnt = 0; end
      end
      if (op_kind == 0) begin
        if (pend && (wcnt >= MW || !host_req_i)) begin
          op_kind = 2; op_t0 = cyc; wcnt = 0;
        end else if (host_req_i) begin
          op_kind = 1; op_t0 = cyc;
          if (pend && wcnt < MW) wcnt++;
        end
      end else if (ph == 2) begin
        op_kind = 0;
      end
      ev = nev; ecnt = necnt; eadr = neadr; pend = npend;
      last_adr = e_adr; last_wdat = e_wdat; last_hdat = e_hdat;
      cyc++;
    end
  end

  // All directed tasks start and end just after a rising edge.
  task automatic reset_checks();
    chk("rst_ack", host_ack_o, 0);      chk("rst_perr", host_perr_o, 0);
    chk("rst_we", ram_we_o, 0);         chk("rst_ev", err_valid_o, 0);
    chk("rst_pd", pass_done_o, 0);      chk("rst_irq", irq_o, 0);
    chk("rst_hdat", host_dat_o, 0);     chk("rst_radr", ram_adr_o, 0);
    chk("rst_rdat", ram_dat_o, 0);      chk("rst_eadr", err_adr_o, 0);
    chk("rst_ecnt", err_cnt_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; host_req_i = 0; err_clr_i = 0; scrub_en_i = 0; irq_en_i = 0;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         output logic [DW-1:0] rd, output logic perr, output int lat);
    host_req_i = 1; host_we_i = we; host_adr_i = adr; host_dat_i = dat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (host_ack_o) break;
      lat++;
      if (lat > 100) begin
        chk("host_timeout", lat, 0);
        break;
      end
      @(posedge clk); #1;
    end
    rd = host_dat_o; perr = host_perr_o;
    @(posedge clk); #1;
    host_req_i = 0;
  endtask

  task automatic wait_pass(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (pass_done_o) break;
      n++;
      if (n > 200) begin
        chk("pass_timeout", n, 0);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          perr, got_ack;
    int            lat, n, k;
    int            ack_t[$];
    rst_n = 0; ram_load = 1; host_req_i = 0; host_we_i = 0; host_adr_i = '0; host_dat_i = '0;
    scrub_en_i = 0; err_clr_i = 0; irq_en_i = 0;
    for (int i = 0; i < MS; i++) bad[i] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    ram_load = 0;
    rst_n = 1;

    // Reset lands in the middle of a host write access: no ack, write dropped.
    host_req_i = 1; host_we_i = 1; host_adr_i = 3'd5; host_dat_i = 32'h1234_5678;
    @(posedge clk); #2;
    do_reset();
    host_op(0, 3'd5, '0, rd, perr, lat);
    chk("rd5_lat", lat, 2);
    chk("rd5_dat", rd, init_word(5));

    host_op(1, 3'd3, 32'hDEAD_BEEF, rd, perr, lat);
    chk("wr3_lat", lat, 2);
    host_op(0, 3'd3, '0, rd, perr, lat);
    chk("rd3_lat", lat, 2);
    chk("rd3_dat", rd, 32'hDEAD_BEEF);
    chk("rd3_perr", perr, 0);

    // Idle scrubbing: one read per 6 cycles, error at word 6.
    @(posedge clk); #1;
    do_reset();
    bad[6] = 1; irq_en_i = 1; scrub_en_i = 1;
    wait_pass(n);
    chk("pass1_cycles", n, 47);
    chk("pass1_adr", ram_adr_o, 7);
    chk("pass1_ev", err_valid_o, 1);
    chk("pass1_eadr", err_adr_o, 6);
    chk("pass1_ecnt", err_cnt_o, 1);
    chk("pass1_irq", irq_o, 1);
    @(posedge clk); #1;
    wait_pass(n);
    chk("pass2_cycles", n, 47);
    chk("pass2_eadr", err_adr_o, 6);
    chk("pass2_ecnt", err_cnt_o, 2);
    @(posedge clk); #1;

    // Host holds the port; the pending scrub gets in after MAX_WAIT host grants.
    do_reset();
    bad[6] = 0; scrub_en_i = 1;
    host_req_i = 1; host_we_i = 0; host_adr_i = AW'($urandom_range(0, MS - 1));
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      got_ack = host_ack_o;
      if (got_ack) ack_t.push_back(k);
      @(posedge clk); #1;
      if (got_ack) host_adr_i = AW'($urandom_range(0, MS - 1));
    end
    host_req_i = 0;
    chk("starve_nacks", ack_t.size(), 9);
    if (ack_t.size() >= 6) begin
      chk("starve_ack4", ack_t[4], 14);
      chk("starve_ack5", ack_t[5], 20);
    end

    // Clear collides with a fresh error at word 2.
    do_reset();
    bad[0] = 1; bad[2] = 1; scrub_en_i = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ram_adr_o == 3'd2 && !ram_we_o) break;
      n++;
      if (n > 100) begin
        chk("adr2_timeout", n, 0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("pre_clr_eadr", err_adr_o, 0);
    @(posedge clk); #1;
    err_clr_i = 1;
    @(posedge clk); #1;
    err_clr_i = 0;
    @(negedge clk);
    chk("clr_ev", err_valid_o, 1);
    chk("clr_ecnt", err_cnt_o, 1);
    chk("clr_eadr", err_adr_o, 2);

    // Every word bad: the counter saturates.
    @(posedge clk); #1;
    for (int i = 0; i < MS; i++) bad[i] = 1;
    repeat (1600) @(posedge clk);
    #1;
    @(negedge clk);
    chk("sat_ecnt", err_cnt_o, 255);
    chk("sat_eadr", err_adr_o, 2);
    @(posedge clk); #1;

    // Random traffic against the model.
    do_reset();
    got_ack = 0;
    for (int c = 0; c < 2500; c++) begin
      if (host_req_i && got_ack) host_req_i = 0;
      if (!host_req_i && $urandom_range(0, 2) == 0) begin
        host_req_i = 1; host_we_i = 1'($urandom_range(0, 1));
        host_adr_i = AW'($urandom_range(0, MS - 1)); host_dat_i = $urandom;
      end
      scrub_en_i = ($urandom_range(0, 7) != 0);
      err_clr_i  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) irq_en_i = 1'($urandom_range(0, 1));
      if (c % 100 == 0) for (int i = 0; i < MS; i++) bad[i] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      got_ack = host_ack_o;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
